// File: rtl/fifo_symbol_scheduler_pkg.sv
`default_nettype none
//==============================================================================
// Module  : fifo_symbol_scheduler_pkg
// Brief   : Modulation codes, scheduler state type and bits-per-symbol decode.
// Rev     : 1.0  initial release
//==============================================================================
package fifo_symbol_scheduler_pkg;

    localparam logic [1:0] MOD_BPSK  = 2'd0;
    localparam logic [1:0] MOD_QPSK  = 2'd1;
    localparam logic [1:0] MOD_16QAM = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_t;

    // The reserved code 3 falls back to BPSK.
    function automatic logic [2:0] bps_decode(input logic [1:0] mod_sel);
        case (mod_sel)
            MOD_QPSK:  return 3'd2;
            MOD_16QAM: return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_symbol_scheduler_if.sv
`default_nettype none
//==============================================================================
// Module  : fifo_symbol_scheduler_if
// Brief   : Control, FIFO read port and symbol output bundle of the scheduler.
// Rev     : 1.0  initial release
//==============================================================================
interface fifo_symbol_scheduler_if #(
    parameter int MAX_BPS = 4
);
    logic               en;
    logic [1:0]         mod_sel;
    logic               fifo_bEmpty;
    logic               fifo_dOut;
    logic               fifo_rEN;
    logic [MAX_BPS-1:0] sym_out;
    logic               sym_valid;
    logic               underrun;
    logic               busy;

    modport master (
        output en, mod_sel, fifo_bEmpty, fifo_dOut,
        input  fifo_rEN, sym_out, sym_valid, underrun, busy
    );

    modport slave (
        input  en, mod_sel, fifo_bEmpty, fifo_dOut,
        output fifo_rEN, sym_out, sym_valid, underrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_symbol_scheduler_sym_tick_gen.sv
`default_nettype none
//==============================================================================
// Module  : sym_tick_gen
// Brief   : Symbol-slot counter; ticks on the last clock of every slot.
// Rev     : 1.0  initial release
//==============================================================================
module sym_tick_gen #(
    parameter int SYM_PERIOD = 8
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic i_clr,
    input  wire logic i_run,
    output logic      o_tick
);
    localparam int             C_W    = $clog2(SYM_PERIOD);
    localparam logic [C_W-1:0] C_LAST = C_W'(SYM_PERIOD - 1);

    logic [C_W-1:0] r_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= (r_count == C_LAST) ? '0 : r_count + C_W'(1);
        end
    end

    assign o_tick = i_run && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_symbol_scheduler.sv
`default_nettype none
//==============================================================================
// Module  : fifo_symbol_scheduler
// Brief   : Drains a 1-bit FIFO into 1/2/4-bit symbols released once per slot.
// Rev     : 1.0  initial release
//==============================================================================
module fifo_symbol_scheduler
    import fifo_symbol_scheduler_pkg::*;
#(
    parameter int SYM_PERIOD = 8,
    parameter int MAX_BPS    = 4
) (
    input  wire logic                  CLK,
    input  wire logic                  RST,
    fifo_symbol_scheduler_if.slave     bus
);
    localparam int C_CNT_W = $clog2(MAX_BPS + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [C_CNT_W-1:0]   r_bps;
    logic [C_CNT_W-1:0]   r_issued;
    logic [C_CNT_W-1:0]   r_got;
    logic [C_CNT_W-1:0]   w_got_next;
    logic [MAX_BPS-1:0]   r_shreg;
    logic [MAX_BPS-1:0]   r_sym_out;
    logic                 r_rd_pend;
    logic                 r_sym_valid;
    logic                 r_underrun;
    logic                 w_tick;
    logic                 w_start;
    logic                 w_release;
    logic                 w_underrun;
    logic                 w_rd_en;

    sym_tick_gen #(
        .SYM_PERIOD (SYM_PERIOD)
    ) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .i_clr  (w_start),
        .i_run  (r_state != IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Completion is judged on the bit count including this cycle's capture,
    // so a tick coinciding with the last bit does not raise underrun.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_release    = 1'b0;
        w_underrun   = 1'b0;
        w_rd_en      = 1'b0;
        w_got_next   = r_got + C_CNT_W'(r_rd_pend);
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_state_next = FETCH;
                    w_start      = 1'b1;
                end
            end
            FETCH: begin
                if (!bus.en) begin
                    w_state_next = IDLE;
                end else begin
                    w_rd_en = !bus.fifo_bEmpty && (r_issued < r_bps);
                    if (w_got_next == r_bps) w_state_next = READY;
                    else if (w_tick)         w_underrun   = 1'b1;
                end
            end
            READY: begin
                if (!bus.en) begin
                    w_state_next = IDLE;
                end else if (w_tick) begin
                    w_state_next = FETCH;
                    w_release    = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The shift register is cleared at every symbol start, so bits above
    // the active symbol width are already zero when it is released.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bps       <= '0;
            r_issued    <= '0;
            r_got       <= '0;
            r_shreg     <= '0;
            r_sym_out   <= '0;
            r_rd_pend   <= 1'b0;
            r_sym_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_sym_valid <= w_release;
            r_underrun  <= w_underrun;
            r_rd_pend   <= w_rd_en;
            if (w_start) r_bps <= C_CNT_W'(bps_decode(bus.mod_sel));
            if (w_release) r_sym_out <= r_shreg;
            if (w_start || w_release) begin
                r_issued <= '0;
                r_got    <= '0;
                r_shreg  <= '0;
            end else begin
                if (w_rd_en) r_issued <= r_issued + C_CNT_W'(1);
                if (r_rd_pend) begin
                    r_shreg <= {r_shreg[MAX_BPS-2:0], bus.fifo_dOut};
                    r_got   <= w_got_next;
                end
            end
        end
    end

    assign bus.fifo_rEN  = w_rd_en;
    assign bus.sym_out   = r_sym_out;
    assign bus.sym_valid = r_sym_valid;
    assign bus.underrun  = r_underrun;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_symbol_scheduler.sv
`default_nettype none
//==============================================================================
// Module  : tb_fifo_symbol_scheduler
// Brief   : Directed and random stimulus against a queue-based symbol model.
// Rev     : 1.0  initial release
//==============================================================================
module tb_fifo_symbol_scheduler;
    localparam int P  = 8;
    localparam int MB = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    fifo_symbol_scheduler_if #(.MAX_BPS(MB)) bus();

    fifo_symbol_scheduler #(
        .SYM_PERIOD (P),
        .MAX_BPS    (MB)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    bit fq[$];
    int syms[$];
    int n_ren;
    int n_under;

    // Reference model: bits gathered in a queue, slot position from a cycle count.
    bit m_busy, m_ready, m_inflight, m_inflight_val, m_valid, m_under;
    int m_phase, m_bps, m_issued, m_sym;
    bit m_bits[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int decode(input bit [1:0] m);
        return (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_ready = 0; m_inflight = 0; m_inflight_val = 0;
        m_valid = 0; m_under = 0; m_phase = 0; m_bps = 1; m_issued = 0; m_sym = 0;
        m_bits.delete();
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit en_i, input bit [1:0] ms_i);
        bit ex_ren, tick, popped, pv;
        bus.en          = en_i;
        bus.mod_sel     = ms_i;
        bus.fifo_bEmpty = (fq.size() == 0);
        #1;
        ex_ren = m_busy && en_i && !m_ready && (fq.size() != 0) && (m_issued < m_bps);
        check_val("fifo_rEN",  {31'd0, bus.fifo_rEN},  {31'd0, ex_ren});
        check_val("busy",      {31'd0, bus.busy},      {31'd0, m_busy});
        check_val("sym_valid", {31'd0, bus.sym_valid}, {31'd0, m_valid});
        check_val("underrun",  {31'd0, bus.underrun},  {31'd0, m_under});
        check_val("sym_out",   {28'd0, bus.sym_out},   m_sym);
        if (bus.sym_valid) syms.push_back(int'(bus.sym_out));
        if (bus.underrun) n_under++;
        popped = 0;
        pv     = 0;
        if (bus.fifo_rEN) begin
            n_ren++;
            if (fq.size() != 0) begin
                pv     = fq.pop_front();
                popped = 1;
            end
        end
        m_valid = 0;
        m_under = 0;
        if (!m_busy) begin
            if (en_i) begin
                m_busy = 1; m_phase = 0; m_bps = decode(ms_i);
                m_bits.delete(); m_issued = 0; m_ready = 0; m_inflight = 0;
            end
        end else if (!en_i) begin
            m_busy     = 0;
            m_inflight = 0;
        end else begin
            tick = ((m_phase % P) == P - 1);
            if (m_inflight) m_bits.push_back(m_inflight_val);
            if (!m_ready) begin
                if (ex_ren) m_issued++;
                if (m_bits.size() == m_bps) m_ready = 1;
                else if (tick)              m_under = 1;
            end else if (tick) begin
                m_sym = 0;
                foreach (m_bits[i]) m_sym = m_sym * 2 + int'(m_bits[i]);
                m_valid = 1;
                m_bits.delete();
                m_issued = 0;
                m_ready  = 0;
            end
            m_inflight     = ex_ren;
            m_inflight_val = pv;
            m_phase++;
        end
        @(posedge CLK);
        #1;
        if (popped) bus.fifo_dOut = pv;
        @(negedge CLK);
    endtask

    task automatic do_reset(input int n, input bit en_i);
        RST             = 1'b0;
        bus.en          = en_i;
        bus.fifo_bEmpty = (fq.size() == 0);
        model_reset();
        for (int i = 0; i < n; i++) begin
            #1;
            check_val("rst_rEN",   {31'd0, bus.fifo_rEN},  32'd0);
            check_val("rst_busy",  {31'd0, bus.busy},      32'd0);
            check_val("rst_valid", {31'd0, bus.sym_valid}, 32'd0);
            check_val("rst_under", {31'd0, bus.underrun},  32'd0);
            check_val("rst_sym",   {28'd0, bus.sym_out},   32'd0);
            @(negedge CLK);
        end
        RST = 1'b1;
    endtask

    initial begin
        bit en_r;
        int rate;
        bus.en = 0; bus.mod_sel = 0; bus.fifo_bEmpty = 1; bus.fifo_dOut = 0;
        model_reset();
        @(negedge CLK);

        // Reset with en high, then a QPSK stream
        fq = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset(3, 1'b1);
        syms.delete(); n_under = 0;
        step(1'b1, 2'd1);
        check_val("busy_after_rst", {31'd0, bus.busy}, 32'd1);
        repeat (39) step(1'b1, 2'd1);
        check_val("qpsk_count", syms.size(), 4);
        check_val("qpsk_sym0", syms[0], 2);
        check_val("qpsk_sym1", syms[1], 3);
        check_val("qpsk_sym2", syms[2], 1);
        check_val("qpsk_sym3", syms[3], 0);
        check_val("qpsk_no_underrun", n_under, 0);
        step(1'b0, 2'd0);

        // 16QAM single symbol
        fq = {1'b1, 1'b1, 1'b0, 1'b1};
        syms.delete(); n_ren = 0;
        repeat (12) step(1'b1, 2'd2);
        check_val("qam_count", syms.size(), 1);
        check_val("qam_sym", syms[0], 13);
        check_val("qam_reads", n_ren, 4);
        step(1'b0, 2'd0);

        // BPSK underrun, then a late bit
        syms.delete(); n_under = 0;
        repeat (10) step(1'b1, 2'd0);
        check_val("bpsk_underrun", n_under, 1);
        check_val("bpsk_no_sym", syms.size(), 0);
        fq.push_back(1'b1);
        repeat (10) step(1'b1, 2'd0);
        check_val("bpsk_late_count", syms.size(), 1);
        check_val("bpsk_late_sym", syms[0], 1);
        step(1'b0, 2'd0);

        // Abort after the first captured bit
        fq = {1'b1, 1'b0, 1'b1, 1'b1};
        syms.delete();
        repeat (3) step(1'b1, 2'd1);
        step(1'b0, 2'd1);
        check_val("abort_idle", {31'd0, bus.busy}, 32'd0);
        check_val("abort_consumed", fq.size(), 2);
        repeat (12) step(1'b1, 2'd1);
        check_val("abort_resume_count", syms.size(), 1);
        check_val("abort_resume_sym", syms[0], 3);
        step(1'b0, 2'd0);

        // Reserved mode, then mod_sel changed while busy
        fq = {1'b1, 1'b0, 1'b1};
        syms.delete();
        step(1'b1, 2'd3);
        repeat (30) step(1'b1, 2'd2);
        check_val("m3_count", syms.size(), 3);
        check_val("m3_sym0", syms[0], 1);
        check_val("m3_sym1", syms[1], 0);
        check_val("m3_sym2", syms[2], 1);
        step(1'b0, 2'd0);

        // Random traffic
        en_r = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rate = ((c / 500) % 2 == 1) ? 10 : 55;
            if ($urandom_range(0, 99) < rate) fq.push_back(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) < 3) en_r = !en_r;
            if ($urandom_range(0, 999) < 3) do_reset(int'($urandom_range(1, 3)), en_r);
            step(en_r, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
